// File: rtl/tetris_pkg.sv
// Shared board geometry, line-clear FSM states and row indexing helpers.
// Imported by the line clear engine and its row shifter.
package tetris_pkg;

  localparam int BOARD_COLS = 4;
  localparam int BOARD_ROWS = 8;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } lce_state_t;

  function automatic int ROW(input int r, input int cols);
    return r * cols;
  endfunction

endpackage

// File: rtl/row_shift_down.sv
// Removes row idx_i from a board, drops every row above it by one
// and inserts an empty top row.
module row_shift_down
  import tetris_pkg::*;
#(
  parameter int COLS = BOARD_COLS,
  parameter int ROWS = BOARD_ROWS,
  parameter int IW   = 3
) (
  input  logic [ROWS*COLS-1:0] board_i,
  input  logic [IW-1:0]        idx_i,
  output logic [ROWS*COLS-1:0] board_o
);

  for (genvar r = 0; r < ROWS - 1; r++) begin : g_row
    assign board_o[ROW(r, COLS) +: COLS] =
      (idx_i > IW'(r)) ? board_i[ROW(r, COLS) +: COLS]
                       : board_i[ROW(r + 1, COLS) +: COLS];
  end

  // idx_i never exceeds ROWS-1, so the top row is always vacated
  assign board_o[ROW(ROWS - 1, COLS) +: COLS] = '0;

endmodule

// File: rtl/line_clear_engine.sv
// Sequential full-row detect/clear/compact engine: one row examined
// per cycle, full rows removed in place, count of cleared lines reported.
module line_clear_engine
  import tetris_pkg::*;
#(
  parameter int  COLS  = BOARD_COLS,
  parameter int  ROWS  = BOARD_ROWS,
  localparam int CNT_W = $clog2(ROWS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ROWS*COLS-1:0] board_in,
  output logic                 busy,
  output logic                 done,
  output logic [ROWS*COLS-1:0] board_out,
  output logic [CNT_W-1:0]     lines_cleared
);

  localparam int PW = (ROWS > 1) ? $clog2(ROWS) : 1;

  if (ROWS < 2) begin : g_chk
    $error("line_clear_engine: ROWS must be >= 2");
  end

  lce_state_t           state_q;
  logic                 busy_q;
  logic                 done_q;
  logic [ROWS*COLS-1:0] board_q;
  logic [CNT_W-1:0]     lines_q;
  logic [ROWS*COLS-1:0] work_q;
  logic [ROWS*COLS-1:0] shift_d;
  logic [PW-1:0]        ptr_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 row_full;

  assign row_full = &work_q[ROW(int'(ptr_q), COLS) +: COLS];

  row_shift_down #(
    .COLS (COLS),
    .ROWS (ROWS),
    .IW   (PW)
  ) u_shift (
    .board_i (work_q),
    .idx_i   (ptr_q),
    .board_o (shift_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      board_q <= '0;
      lines_q <= '0;
      work_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            work_q  <= board_in;
            ptr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          // a cleared row pulls new data into ptr, so ptr stays put
          if (row_full) begin
            work_q <= shift_d;
            cnt_q  <= cnt_q + CNT_W'(1);
          end else if (ptr_q == PW'(ROWS - 1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            board_q <= work_q;
            lines_q <= cnt_q;
          end else begin
            ptr_q <= ptr_q + PW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign board_out     = board_q;
  assign lines_cleared = lines_q;

endmodule

// File: tb/tb_line_clear_engine.sv
// Bench for line_clear_engine: directed 8x4 scenarios plus random
// 20x10 boards compared against a row-list compaction model.
module tb_line_clear_engine;

  localparam int RA = 8;
  localparam int CA = 4;
  localparam int RB = 20;
  localparam int CB = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             start_a;
  logic [RA*CA-1:0] board_a;
  logic             busy_a;
  logic             done_a;
  logic [RA*CA-1:0] out_a;
  logic [3:0]       lc_a;

  logic             start_b;
  logic [RB*CB-1:0] board_b;
  logic             busy_b;
  logic             done_b;
  logic [RB*CB-1:0] out_b;
  logic [4:0]       lc_b;

  int checks   = 0;
  int failures = 0;

  line_clear_engine #(.COLS(CA), .ROWS(RA)) dut_a (
    .clk           (clk),
    .rst           (rst),
    .start         (start_a),
    .board_in      (board_a),
    .busy          (busy_a),
    .done          (done_a),
    .board_out     (out_a),
    .lines_cleared (lc_a)
  );

  line_clear_engine #(.COLS(CB), .ROWS(RB)) dut_b (
    .clk           (clk),
    .rst           (rst),
    .start         (start_b),
    .board_in      (board_b),
    .busy          (busy_b),
    .done          (done_b),
    .board_out     (out_b),
    .lines_cleared (lc_b)
  );

  task automatic run_a(input logic [31:0] b, input int restart_at,
                       output logic [31:0] o, output logic [3:0] lc,
                       output int lat, output int nd);
    lat = -1;
    nd  = 0;
    o   = '0;
    lc  = '0;
    @(negedge clk);
    board_a = b;
    start_a = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      start_a = (c == restart_at);
      if (c == 1) board_a = $urandom;
      if (done_a) begin
        nd++;
        if (lat < 0) begin
          lat = c;
          o   = out_a;
          lc  = lc_a;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    board_a = '0;
    board_b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl got busy=%b done=%b want 0 0", busy_a, done_a);
    end
    checks++;
    if (out_a !== '0 || lc_a !== '0) begin
      failures++;
      $display("FAIL reset_out got %h/%0d want 0/0", out_a, lc_a);
    end
    checks++;
    if (busy_b !== 1'b0 || done_b !== 1'b0 || out_b !== '0 || lc_b !== '0) begin
      failures++;
      $display("FAIL reset_b got busy=%b done=%b lc=%0d want zeros", busy_b, done_b, lc_b);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed(input string nm, input logic [31:0] b,
                               input int restart_at, input logic [31:0] eo,
                               input int ek, input int elat);
    logic [31:0] o;
    logic [3:0]  lc;
    int          lat;
    int          nd;
    run_a(b, restart_at, o, lc, lat, nd);
    checks++;
    if (o !== eo) begin
      failures++;
      $display("FAIL %s_board got %h want %h", nm, o, eo);
    end
    checks++;
    if (int'(lc) !== ek) begin
      failures++;
      $display("FAIL %s_lines got %0d want %0d", nm, lc, ek);
    end
    checks++;
    if (lat !== elat) begin
      failures++;
      $display("FAIL %s_latency got %0d want %0d", nm, lat, elat);
    end
    checks++;
    if (nd !== 1) begin
      failures++;
      $display("FAIL %s_done_count got %0d want 1", nm, nd);
    end
  endtask

  task automatic test_mid_reset();
    int nd;
    test_directed("pre_reset", 32'h0000_03F1, 0, 32'h0000_0031, 1, RA + 2);
    @(negedge clk);
    board_a = 32'hFFFF_FFFF;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (busy_a !== 1'b1) begin
      failures++;
      $display("FAIL mid_busy got %b want 1", busy_a);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      failures++;
      $display("FAIL abort_ctrl got busy=%b done=%b want 0 0", busy_a, done_a);
    end
    checks++;
    if (out_a !== '0 || lc_a !== '0) begin
      failures++;
      $display("FAIL abort_out got %h/%0d want 0/0", out_a, lc_a);
    end
    @(negedge clk);
    rst = 1'b0;
    nd  = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (done_a) nd++;
    end
    checks++;
    if (nd !== 0) begin
      failures++;
      $display("FAIL abort_no_done got %0d pulses want 0", nd);
    end
  endtask

  task automatic test_random();
    logic [RB*CB-1:0] b;
    logic [RB*CB-1:0] eo;
    logic [CB-1:0]    row;
    int               k;
    int               j;
    int               lat;
    logic [RB*CB-1:0] o;
    logic [4:0]       lc;
    for (int it = 0; it < 1000; it++) begin
      for (int r = 0; r < RB; r++) begin
        if ($urandom_range(2) == 0) row = '1;
        else row = CB'($urandom);
        b[r*CB +: CB] = row;
      end
      eo = '0;
      k  = 0;
      j  = 0;
      for (int r = 0; r < RB; r++) begin
        row = b[r*CB +: CB];
        if (&row) k++;
        else begin
          eo[j*CB +: CB] = row;
          j++;
        end
      end
      lat = -1;
      o   = '0;
      lc  = '0;
      @(negedge clk);
      board_b = b;
      start_b = 1'b1;
      for (int c = 1; c <= 60; c++) begin
        @(posedge clk);
        #1;
        if (c == 1) begin
          start_b = 1'b0;
          board_b = '0;
        end
        if (done_b) begin
          lat = c;
          o   = out_b;
          lc  = lc_b;
          break;
        end
      end
      @(posedge clk);
      checks++;
      if (o !== eo) begin
        failures++;
        $display("FAIL rand%0d_board got %h want %h", it, o, eo);
      end
      checks++;
      if (int'(lc) !== k) begin
        failures++;
        $display("FAIL rand%0d_lines got %0d want %0d", it, lc, k);
      end
      checks++;
      if (lat !== RB + k + 1) begin
        failures++;
        $display("FAIL rand%0d_latency got %0d want %0d", it, lat, RB + k + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed("empty", 32'h0000_0000, 0, 32'h0000_0000, 0, RA + 1);
    test_directed("row0", 32'h0000_000F, 0, 32'h0000_0000, 1, RA + 2);
    test_directed("partial", 32'h0000_03F1, 0, 32'h0000_0031, 1, RA + 2);
    test_directed("all_full", 32'hFFFF_FFFF, 0, 32'h0000_0000, 8, 2 * RA + 1);
    test_directed("busy_ignore", 32'hF0F0_F0F0, 3, 32'h0000_0000, 4, RA + 5);
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
